// File: rtl/xor_gate_pkg.sv
// rtl/xor_gate_pkg.sv - shared defaults and popcount helper for the xor gate core
package xor_gate_pkg;

  localparam int unsigned XOR_WIDTH_DEF = 1;
  localparam int unsigned XOR_CNT_W_DEF = 16;
  localparam int unsigned XOR_WIDTH_MAX = 64;

  // Operands are zero-extended to the widest legal width; callers narrow the result.
  function automatic logic [6:0] popcount(input logic [XOR_WIDTH_MAX-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < XOR_WIDTH_MAX; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/xor_gate_popcount.sv
// rtl/xor_gate_popcount.sv - combinational set-bit count of a WIDTH-bit word
module xor_gate_popcount
  import xor_gate_pkg::*;
#(
  parameter int unsigned WIDTH = XOR_WIDTH_DEF,
  parameter int unsigned POP_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [POP_W-1:0] cnt
);

  logic [XOR_WIDTH_MAX-1:0] din_ext;

  assign din_ext = XOR_WIDTH_MAX'(din);
  assign cnt     = POP_W'(popcount(din_ext));

endmodule

// File: rtl/xor_gate_core.sv
// rtl/xor_gate_core.sv - combinational xor with registered, qualified result and
// saturating count of differing bits
module xor_gate_core
  import xor_gate_pkg::*;
#(
  parameter int unsigned WIDTH = XOR_WIDTH_DEF,
  parameter int unsigned CNT_W = XOR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             in_valid,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_q,
  output logic             parity_q,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] y_d,   y_q_r;
  logic             par_d, par_q;
  logic             ov_d,  ov_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   cnt_sum;

  assign y = a ^ b;

  xor_gate_popcount #(
    .WIDTH (WIDTH),
    .POP_W (POP_W)
  ) u_popcount (
    .din (y),
    .cnt (pop)
  );

  // One spare bit catches the carry so saturation never wraps.
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(pop);

  always_comb begin
    y_d   = y_q_r;
    par_d = par_q;
    ov_d  = 1'b0;
    cnt_d = cnt_q;
    if (in_valid) begin
      y_d   = y;
      par_d = ^y;
    end
    // clear wins over in_valid: data is still captured but not counted or flagged.
    if (clear) begin
      cnt_d = '0;
    end else if (in_valid) begin
      ov_d  = 1'b1;
      cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r <= '0;
      par_q <= 1'b0;
      ov_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      y_q_r <= y_d;
      par_q <= par_d;
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
    end
  end

  assign y_q          = y_q_r;
  assign parity_q     = par_q;
  assign out_valid    = ov_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_xor_gate_core.sv
// tb/tb_xor_gate_core.sv - self-checking bench for xor_gate_core
module tb_xor_gate_core;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;

  logic [7:0] a, b, y, y_q, mismatch_cnt;
  logic       in_valid, clear, out_valid, parity_q;

  logic        a1, b1, y1, y_q1, in_valid1, clear1, out_valid1, parity_q1;
  logic [15:0] cnt1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [7:0] m_yq, m_cnt;
  logic       m_par, m_ov;

  always #5 if (clk_run) clk = ~clk;

  xor_gate_core #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .y(y),
    .in_valid(in_valid), .clear(clear), .out_valid(out_valid),
    .y_q(y_q), .parity_q(parity_q), .mismatch_cnt(mismatch_cnt)
  );

  xor_gate_core dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .y(y1),
    .in_valid(in_valid1), .clear(clear1), .out_valid(out_valid1),
    .y_q(y_q1), .parity_q(parity_q1), .mismatch_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the registered outputs must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq = 8'h00; m_par = 1'b0; m_ov = 1'b0; m_cnt = 8'h00;
    end else begin
      int n;
      n = $countones(a ^ b);
      if (in_valid) begin
        m_yq  = a ^ b;
        m_par = n[0];
      end
      if (clear) begin
        m_cnt = 8'h00; m_ov = 1'b0;
      end else if (in_valid) begin
        m_ov  = 1'b1;
        m_cnt = (int'(m_cnt) + n > 255) ? 8'hFF : 8'(int'(m_cnt) + n);
      end else begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("y", 64'(y), 64'(a ^ b));
      chk("y_q", 64'(y_q), 64'(m_yq));
      chk("parity_q", 64'(parity_q), 64'(m_par));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("mismatch_cnt", 64'(mismatch_cnt), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [7:0] na, input logic [7:0] nb, input logic v, input logic c);
    a = na; b = nb; in_valid = v; clear = c;
  endtask

  initial begin
    logic [3:0] tt;
    tt = 4'b0110;
    set_in(8'h00, 8'h00, 1'b0, 1'b0);
    a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b1; clear1 = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;

    // Clock idle: combinational truth table only, nothing may be captured.
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      #10;
      chk("y1_truth", 64'(y1), 64'(tt[i]));
    end
    chk("y_q1_idle", 64'(y_q1), 64'h0);
    chk("out_valid1_idle", 64'(out_valid1), 64'h0);
    chk("cnt1_idle", 64'(cnt1), 64'h0);
    in_valid1 = 1'b0;

    clk_run = 1'b1;
    cmp_en  = 1'b1;
    step();

    set_in(8'hF0, 8'h3C, 1'b1, 1'b0);
    #1;
    chk("y_immediate", 64'(y), 64'hCC);
    step();
    chk("lit_y_q_cc", 64'(y_q), 64'hCC);
    chk("lit_parity_cc", 64'(parity_q), 64'h0);
    chk("lit_ov_cc", 64'(out_valid), 64'h1);
    chk("lit_cnt_4", 64'(mismatch_cnt), 64'd4);
    set_in(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk("lit_ov_idle", 64'(out_valid), 64'h0);

    set_in(8'h01, 8'h03, 1'b1, 1'b0);
    step();
    set_in(8'hFF, 8'hFF, 1'b0, 1'b0);
    step();
    chk("lit_y_q_hold", 64'(y_q), 64'h02);
    chk("lit_ov_gap", 64'(out_valid), 64'h0);
    set_in(8'h07, 8'h00, 1'b1, 1'b0);
    step();
    chk("lit_ov_again", 64'(out_valid), 64'h1);
    chk("lit_parity_07", 64'(parity_q), 64'h1);
    chk("lit_cnt_8", 64'(mismatch_cnt), 64'd8);

    set_in(8'h00, 8'h01, 1'b1, 1'b1);
    step();
    chk("lit_clear_cnt", 64'(mismatch_cnt), 64'h0);
    chk("lit_clear_ov", 64'(out_valid), 64'h0);
    chk("lit_clear_y_q", 64'(y_q), 64'h01);

    set_in(8'hFF, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 31) chk("lit_cnt_248", 64'(mismatch_cnt), 64'd248);
    end
    chk("lit_cnt_sat", 64'(mismatch_cnt), 64'd255);
    set_in(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk("lit_cnt_sat_hold", 64'(mismatch_cnt), 64'd255);

    set_in(8'hAA, 8'h0F, 1'b1, 1'b0);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #0.5;
    chk("lit_rst_y_q", 64'(y_q), 64'h0);
    chk("lit_rst_parity", 64'(parity_q), 64'h0);
    chk("lit_rst_ov", 64'(out_valid), 64'h0);
    chk("lit_rst_cnt", 64'(mismatch_cnt), 64'h0);
    chk("lit_rst_y_live", 64'(y), 64'hA5);
    repeat (2) step();
    rst_n = 1'b1;
    set_in(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    set_in(8'h03, 8'h00, 1'b1, 1'b0);
    step();
    chk("lit_post_rst_cnt", 64'(mismatch_cnt), 64'd2);
    chk("lit_post_rst_ov", 64'(out_valid), 64'h1);
    set_in(8'h00, 8'h00, 1'b0, 1'b0);
    step();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_gate_core.md
# xor_gate_core

Bitwise exclusive-OR datapath cell with a registered, handshaked copy of the result and per-transfer mismatch statistics. Primary output `y` is purely combinational, so the block drops in wherever a plain two-input XOR is expected. The registered side (`y_q`, parity, mismatch counter) serves compare/checksum logic that needs a clocked, qualified result.

## Interface
- `WIDTH`, default 1: operand width in bits; legal range 1..64.
- `CNT_W`, default 16: mismatch counter width in bits; legal range 8..32.

- `clk`  in  1  single clock; all registers update on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `y`  out  WIDTH  combinational `a ^ b`.
- `in_valid`  in  1  qualifies `a`/`b` for capture.
- `clear`  in  1  synchronous clear of statistics.
- `out_valid`  out  1  `y_q`/`parity_q` hold a captured result.
- `y_q`  out  WIDTH  registered `a ^ b` from the last accepted transfer.
- `parity_q`  out  1  reduction XOR of `y_q`.
- `mismatch_cnt`  out  CNT_W  saturating sum of differing bits over accepted transfers.

## Operation
- `y = a ^ b`, bitwise, at all times, independent of `clk`, `rst_n`, `in_valid`.
  - 1-bit truth table: 00→0, 01→1, 10→1, 11→0.
  - X/Z on an input bit propagates as X on that `y` bit only.
- An edge with `in_valid`=1 is an accepted transfer:
  - `y_q` ← `a ^ b`.
  - `parity_q` ← reduction XOR of `a ^ b`.
  - `out_valid` ← 1.
  - `mismatch_cnt` ← `mismatch_cnt` + popcount(`a ^ b`), saturating at 2^CNT_W−1; never wraps.
- An edge with `in_valid`=0: `y_q` and `parity_q` hold; `out_valid` ← 0; counter holds.
- `clear`=1:
  - `mismatch_cnt` ← 0 and `out_valid` ← 0.
  - `y_q` and `parity_q` hold.
  - `clear` has priority over `in_valid` in the same cycle. Data is still captured, but nothing is counted and `out_valid` stays 0.
- No backpressure: every `in_valid` beat is accepted.
- Popcount is computed at width ceil(log2(WIDTH+1)) and zero-extended before the saturating add.

## Timing
- `y`: zero-cycle combinational path, no registers.
- Registered outputs: 1-cycle latency from the accepting edge.
- Reset (`rst_n`=0, asynchronous) clears every register immediately, regardless of `clk`:
  - `y_q` = 0, `parity_q` = 0, `out_valid` = 0, `mismatch_cnt` = 0.
  - `y` stays live during reset.
- Reset asserted mid-stream discards any in-flight capture.
- First accepted transfer after `rst_n` rises is the first edge with `in_valid`=1.

## Structure
- Shared package `xor_gate_pkg`: `WIDTH`/`CNT_W` default constants and the `popcount` function.
- One natural sub-module, `xor_gate_popcount`: combinational, WIDTH in, ceil(log2(WIDTH+1)) bits out. The top holds the combinational XOR, the capture registers and the saturating counter.

## Test plan
- WIDTH=1, `clk` idle, apply ab=00,01,10,11 with 10 ns holds → `y`=0,1,1,0 each time; registered outputs stay at reset values.
- WIDTH=8, reset released, `a`=8'hF0, `b`=8'h3C, `in_valid` one cycle:
  - `y`=8'hCC immediately.
  - Next edge: `y_q`=8'hCC, `parity_q`=0, `out_valid`=1, `mismatch_cnt`=4.
- WIDTH=8, CNT_W=8, 40 accepted beats of `a`=8'hFF, `b`=8'h00 → `mismatch_cnt` saturates at 255 and holds.
- `clear` and `in_valid` both high with `a`^`b`=8'h01:
  - `mismatch_cnt`=0, `out_valid`=0, `y_q`=8'h01.
- Assert `rst_n`=0 between clock edges after nonzero state:
  - All registered outputs 0 at once; `y` still tracks `a ^ b`.
- `in_valid` toggling 1,0,1 → `out_valid` pulses 1,0,1 one cycle later; `y_q` holds during the idle cycle.
